// File: rtl/jtkcpu_idxseq_pkg.sv
// Shared constants for the indexed-addressing sequencer: postbyte field
// layout, mode and register codes, accumulator/delta codes and FSM states.
package jtkcpu_idx_pkg;

    // Postbyte field positions
    localparam int PB_IND     = 7;
    localparam int PB_REG_HI  = 6;
    localparam int PB_REG_LO  = 4;
    localparam int PB_MODE_HI = 3;

    // Addressing modes, postbyte[3:0]
    localparam logic [3:0] MODE_R     = 4'h0;  // ,R
    localparam logic [3:0] MODE_RINC1 = 4'h1;  // ,R+
    localparam logic [3:0] MODE_RINC2 = 4'h2;  // ,R++
    localparam logic [3:0] MODE_RDEC1 = 4'h3;  // ,-R
    localparam logic [3:0] MODE_RDEC2 = 4'h4;  // ,--R
    localparam logic [3:0] MODE_N8    = 4'h5;  // n8,R
    localparam logic [3:0] MODE_N16   = 4'h6;  // n16,R
    localparam logic [3:0] MODE_ACCA  = 4'h7;  // A,R
    localparam logic [3:0] MODE_ACCB  = 4'h8;  // B,R
    localparam logic [3:0] MODE_ACCD  = 4'h9;  // D,R
    localparam logic [3:0] MODE_EXT   = 4'hA;  // extended
    localparam logic [3:0] MODE_DIR   = 4'hB;  // direct page

    // Index registers, postbyte[6:4]; codes above REG_PC are reserved
    localparam logic [2:0] REG_X  = 3'd0;
    localparam logic [2:0] REG_Y  = 3'd1;
    localparam logic [2:0] REG_U  = 3'd2;
    localparam logic [2:0] REG_S  = 3'd3;
    localparam logic [2:0] REG_PC = 3'd4;

    // Accumulator-offset mux codes
    localparam logic [2:0] ACC_A  = 3'd0;
    localparam logic [2:0] ACC_B  = 3'd1;
    localparam logic [2:0] ACC_D  = 3'd2;
    localparam logic [2:0] ACC_M1 = 3'd3;
    localparam logic [2:0] ACC_M2 = 3'd4;

    // Write-back delta: bit1 = negative, bit0 = magnitude two
    localparam logic [1:0] UPD_P1 = 2'b00;
    localparam logic [1:0] UPD_P2 = 2'b01;
    localparam logic [1:0] UPD_M1 = 2'b10;
    localparam logic [1:0] UPD_M2 = 2'b11;

    // Bit positions in the strobe vector {idx_8,idx_16,idx_acc,idx_ld,idx_dp,data2addr}
    localparam int STB_8   = 5;
    localparam int STB_16  = 4;
    localparam int STB_ACC = 3;
    localparam int STB_LD  = 2;
    localparam int STB_DP  = 1;
    localparam int STB_D2A = 0;

    typedef enum logic [1:0] {
        CLS_REG     = 2'd0,
        CLS_FETCH   = 2'd1,
        CLS_ILLEGAL = 2'd2
    } mode_class_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OFS   = 3'd1,
        ST_CALC  = 3'd2,
        ST_IND   = 3'd3,
        ST_INDLD = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/jtkcpu_idxseq_dec.sv
// Combinational postbyte decoder: classifies the mode and produces the
// CALC-cycle strobe vector, accumulator select and write-back request.
module jtkcpu_idxseq_dec
    import jtkcpu_idx_pkg::*;
(
    input  logic [7:0] postbyte,
    output logic [1:0] mode_class,
    output logic       needs_fetch,
    output logic       fetch_len,
    output logic       indirect,
    output logic [5:0] strobes,
    output logic [2:0] acc_sel,
    output logic       upd_we,
    output logic [1:0] upd_delta,
    output logic       illegal
);

    logic [3:0] mode;
    logic [2:0] regf;

    assign mode = postbyte[PB_MODE_HI:0];
    assign regf = postbyte[PB_REG_HI:PB_REG_LO];

    // Mode table; a reserved mode or register suppresses every action
    always_comb begin
        illegal     = 1'b0;
        needs_fetch = 1'b0;
        fetch_len   = 1'b0;
        strobes     = '0;
        acc_sel     = ACC_A;
        upd_we      = 1'b0;
        upd_delta   = UPD_P1;
        case (mode)
            MODE_R:     strobes[STB_LD] = 1'b1;
            MODE_RINC1: begin strobes[STB_LD] = 1'b1; upd_we = 1'b1; upd_delta = UPD_P1; end
            MODE_RINC2: begin strobes[STB_LD] = 1'b1; upd_we = 1'b1; upd_delta = UPD_P2; end
            MODE_RDEC1: begin
                strobes[STB_ACC] = 1'b1; acc_sel = ACC_M1;
                upd_we = 1'b1; upd_delta = UPD_M1;
            end
            MODE_RDEC2: begin
                strobes[STB_ACC] = 1'b1; acc_sel = ACC_M2;
                upd_we = 1'b1; upd_delta = UPD_M2;
            end
            MODE_N8:    begin needs_fetch = 1'b1; strobes[STB_8] = 1'b1; end
            MODE_N16:   begin needs_fetch = 1'b1; fetch_len = 1'b1; strobes[STB_16] = 1'b1; end
            MODE_ACCA:  begin strobes[STB_ACC] = 1'b1; acc_sel = ACC_A; end
            MODE_ACCB:  begin strobes[STB_ACC] = 1'b1; acc_sel = ACC_B; end
            MODE_ACCD:  begin strobes[STB_ACC] = 1'b1; acc_sel = ACC_D; end
            MODE_EXT:   begin needs_fetch = 1'b1; fetch_len = 1'b1; strobes[STB_D2A] = 1'b1; end
            MODE_DIR:   begin needs_fetch = 1'b1; strobes[STB_DP] = 1'b1; end
            default:    illegal = 1'b1;
        endcase
        // Direct page addressing has no index register, so its field is ignored
        if (mode != MODE_DIR && regf > REG_PC) illegal = 1'b1;
        if (illegal) begin
            needs_fetch = 1'b0;
            fetch_len   = 1'b0;
            strobes     = '0;
            acc_sel     = ACC_A;
            upd_we      = 1'b0;
            upd_delta   = UPD_P1;
        end
        indirect = postbyte[PB_IND] && (mode != MODE_DIR) && !illegal;
        if (illegal)          mode_class = CLS_ILLEGAL;
        else if (needs_fetch) mode_class = CLS_FETCH;
        else                  mode_class = CLS_REG;
    end

endmodule

// File: rtl/jtkcpu_idxseq.sv
// Indexed-addressing sequencer: walks offset fetch, address calculation and
// optional indirect load, then pulses done for the main CPU FSM.
module jtkcpu_idxseq
    import jtkcpu_idx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       start,
    input  logic [7:0] postbyte,
    output logic       rd_req,
    output logic       rd_len,
    output logic       rd_ind,
    input  logic       rd_ack,
    output logic       idx_8,
    output logic       idx_16,
    output logic       idx_acc,
    output logic       idx_ld,
    output logic       idx_dp,
    output logic       data2addr,
    output logic [2:0] acc_sel,
    output logic [2:0] reg_sel,
    output logic       upd_we,
    output logic [1:0] upd_delta,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    state_t     state, state_nx;
    logic [7:0] pb_q;
    logic [7:0] dec_pb;

    logic [1:0] dec_class;
    logic       dec_fetch;
    logic       dec_len;
    logic       dec_ind;
    logic [5:0] dec_stb;
    logic [2:0] dec_acc;
    logic       dec_we;
    logic [1:0] dec_delta;
    logic       dec_ill;

    // While idle the decoder looks at the incoming postbyte so the first
    // transition can be chosen in the start cycle; afterwards at the latched one.
    assign dec_pb = (state == ST_IDLE) ? postbyte : pb_q;

    jtkcpu_idxseq_dec u_dec (
        .postbyte    (dec_pb),
        .mode_class  (dec_class),
        .needs_fetch (dec_fetch),
        .fetch_len   (dec_len),
        .indirect    (dec_ind),
        .strobes     (dec_stb),
        .acc_sel     (dec_acc),
        .upd_we      (dec_we),
        .upd_delta   (dec_delta),
        .illegal     (dec_ill)
    );

    // State register and postbyte latch, advancing only on clock-enable
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pb_q  <= '0;
        end else if (cen) begin
            state <= state_nx;
            if (state == ST_IDLE && start) pb_q <= postbyte;
        end
    end

    // Next-state selection and Moore outputs decoded from the current state
    always_comb begin
        state_nx  = state;
        rd_req    = 1'b0;
        rd_len    = 1'b0;
        rd_ind    = 1'b0;
        idx_8     = 1'b0;
        idx_16    = 1'b0;
        idx_acc   = 1'b0;
        idx_ld    = 1'b0;
        idx_dp    = 1'b0;
        data2addr = 1'b0;
        acc_sel   = ACC_A;
        upd_we    = 1'b0;
        upd_delta = UPD_P1;
        done      = 1'b0;
        illegal   = 1'b0;
        busy      = (state != ST_IDLE);
        reg_sel   = (state != ST_IDLE) ? pb_q[PB_REG_HI:PB_REG_LO] : REG_X;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (dec_class == CLS_ILLEGAL)    state_nx = ST_DONE;
                    else if (dec_class == CLS_FETCH) state_nx = ST_OFS;
                    else                             state_nx = ST_CALC;
                end
            end
            ST_OFS: begin
                rd_req = dec_fetch;
                rd_len = dec_len;
                if (rd_ack) state_nx = ST_CALC;
            end
            ST_CALC: begin
                {idx_8, idx_16, idx_acc, idx_ld, idx_dp, data2addr} = dec_stb;
                acc_sel   = dec_acc;
                upd_we    = dec_we;
                upd_delta = dec_delta;
                state_nx  = dec_ind ? ST_IND : ST_DONE;
            end
            ST_IND: begin
                rd_req = 1'b1;
                rd_len = 1'b1;
                rd_ind = 1'b1;
                if (rd_ack) state_nx = ST_INDLD;
            end
            ST_INDLD: begin
                data2addr = 1'b1;
                state_nx  = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                illegal  = dec_ill;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: doc/jtkcpu_idxseq.md
Name: jtkcpu_idxseq

Overview:
- Sequencer for the indexed-addressing datapath (jtkcpu_idx): decodes the indexed postbyte and requests offset/indirect operand fetches.
- Drives the one-hot idx_* control strobes, the accumulator-offset select and index-register write-back (auto inc/dec).
- Signals completion to the main CPU FSM.
- Sits between the instruction-control FSM, the bus/fetch unit and jtkcpu_idx.

Parameters:
- none

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; all state advances only when cen=1
- start  in  1  begin an indexed address calculation; sampled only in IDLE
- postbyte  in  8  indexed postbyte, sampled with start
- rd_req  out  1  request operand read from fetch unit
- rd_len  out  1  0 = 1 byte, 1 = 2 bytes (big-endian into mdata)
- rd_ind  out  1  read at current idx addr (indirect) instead of PC stream
- rd_ack  in  1  mdata valid this cen cycle; ends request
- idx_8, idx_16, idx_acc, idx_ld, idx_dp, data2addr  out  1 each  strobes to jtkcpu_idx
- acc_sel  out  3  racc mux: 0=A, 1=B, 2=D, 3=-1, 4=-2
- reg_sel  out  3  index register: 0=X, 1=Y, 2=U, 3=S, 4=PC
- upd_we  out  1  write back reg_sel += upd_delta
- upd_delta  out  2  signed delta: +1, +2, -1, -2
- busy  out  1  high from accepted start until done
- done  out  1  one-cen-cycle pulse; addr in jtkcpu_idx is final
- illegal  out  1  one-cen-cycle pulse with done on a reserved mode

Behaviour:
- Reset (rst=1 at posedge clk, regardless of cen): state=IDLE; every output 0; acc_sel=0; reg_sel=0.
- Reset mid-operation abandons the sequence with no register write-back.
- Postbyte fields (constants in package):
  - [7] indirect
  - [6:4] register (5–7 illegal)
  - [3:0] mode: 0 ,R; 1 ,R+; 2 ,R++; 3 ,-R; 4 ,--R; 5 n8,R; 6 n16,R; 7 A,R; 8 B,R; 9 D,R; A ext; B direct; C–F illegal
- Direct mode ignores [7] and [6:4].
- States: IDLE, OFS, CALC, IND, INDLD, DONE.
- IDLE:
  - start&cen → latch postbyte, busy=1.
  - Modes 5, 6, A, B → OFS. rd_len=1 for modes 6 and A; rd_len=0 for modes 5 and B.
  - Any illegal mode → DONE with illegal=1.
  - All other modes → CALC.
- OFS: rd_req held high until rd_ack&cen, then → CALC. rd_req stays high indefinitely without rd_ack.
- CALC: exactly one strobe for one cen cycle.
  - Modes 0, 1, 2 → idx_ld, acc_sel irrelevant.
  - Mode 3 → idx_acc with acc_sel=3; mode 4 → idx_acc with acc_sel=4.
  - Modes 7/8/9 → idx_acc with acc_sel 0/1/2.
  - Mode 5 → idx_8; mode 6 → idx_16; mode A → data2addr; mode B → idx_dp.
  - upd_we pulses in the same cycle: modes 1/2/3/4 with upd_delta +1/+2/-1/-2.
  - Next state: IND if indirect and mode≠B, else DONE.
- IND: rd_req=1, rd_len=1, rd_ind=1 until rd_ack&cen, then → INDLD.
- INDLD: data2addr pulse → DONE.
- DONE: done=1 (illegal as latched) for one cen cycle → IDLE; busy falls with the exit.
- Latency in cen cycles, zero-wait fetch:
  - ,R = 2
  - n8,R = 3
  - [n16,R] = 5
- start while busy is ignored.
- start in the same cycle as DONE is ignored; it is accepted the following cycle.
- Strobes are mutually exclusive by construction; a bench assertion checks onehot0.

Decomposition:
- Package jtkcpu_idx_pkg:
  - mode and register localparams
  - acc_sel and upd_delta codes
  - state encoding
- Sub-module jtkcpu_idxseq_dec: combinational postbyte → {mode class, needs_fetch, fetch_len, strobe vector, upd_we, upd_delta, illegal}.
- The FSM stays in the top module.

Test Plan:
- Postbyte 0x01 (,X+), start, cen=1 → CALC: idx_ld=1, reg_sel=0, upd_we=1, upd_delta=+1; done on cycle 2; no rd_req.
- Postbyte 0x16 (n16,Y), rd_ack 3 cycles late with mdata=0x1234 → rd_len=1 held 4 cycles; then idx_16=1, reg_sel=1; done 2 cycles after ack.
- Postbyte 0x84 ([,--X]) → idx_acc with acc_sel=4 and upd_delta=-2 in the same cycle; IND with rd_ind=1; data2addr pulse; done; latency 4 with zero-wait ack.
- Postbyte 0x0B (direct), mdata=0x0056 → idx_dp pulse, no IND even if bit7 set (0x8B); done.
- Postbyte 0x0E and 0x50 → done and illegal pulse 1 cycle after start, no strobes, no upd_we.
- cen toggled 1/0 and rst asserted in OFS → state frozen while cen=0; after rst all outputs 0, busy=0, no write-back; a new start is accepted next cycle.
